// File: rtl/femto_bus_pkg.sv
// femto_bus_pkg
//   Shared constants and types for the FemtoRV32 memory-bus fabric:
//   the error read-data pattern, error-log codes, the fabric FSM state
//   encoding and the default SoC slave base-address table.
package femto_bus_pkg;

    // Pattern returned for unmapped, quarantined and aborted reads.
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    // Error-log codes.
    localparam logic [1:0] ERR_NONE     = 2'b00,
                           ERR_UNMAPPED = 2'b01,
                           ERR_RD_TO    = 2'b10,
                           ERR_WR_TO    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2
    } state_e;

    // Default SoC map: flash, SPI RAM, UART and accelerators.
    // Slice [i*16 +: 16] is the cpu_addr[31:16] value of slave i, so the
    // list reads from slave 6 (left, MSB) down to slave 0 (right, LSB).
    localparam int              DEFAULT_N_SLAVES   = 7;
    localparam logic [16*7-1:0] DEFAULT_SLAVE_BASE = {
        16'h0044, 16'h0043, 16'h0042, 16'h0041, 16'h0040, 16'h0001, 16'h0000
    };

endpackage

// File: rtl/femto_bus_if.sv
// femto_bus_if
//   CPU-side bus of the fabric.
//   cpu_addr/cpu_wdata/cpu_wmask/cpu_rstrb : driven by the CPU (master)
//   cpu_rdata/cpu_rbusy/cpu_wbusy          : driven by the fabric (slave)
//
// Handshake: cpu_rstrb is a one-cycle read request; any set bit of
// cpu_wmask is a write request. A request is accepted in the cycle it is
// presented; the transfer is complete in the first following cycle where
// the matching busy (cpu_rbusy for reads, cpu_wbusy for writes) is low.
// Read data is valid in that completion cycle. Requests must not be
// issued while busy is high.
interface femto_bus_if;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wmask;
    logic        cpu_rstrb;
    logic [31:0] cpu_rdata;
    logic        cpu_rbusy;
    logic        cpu_wbusy;

    modport master (
        output cpu_addr, cpu_wdata, cpu_wmask, cpu_rstrb,
        input  cpu_rdata, cpu_rbusy, cpu_wbusy
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_wmask, cpu_rstrb,
        output cpu_rdata, cpu_rbusy, cpu_wbusy
    );
endinterface

// File: rtl/femto_bus_decode.sv
// femto_bus_decode
//   Combinational address matcher.
//   addr_hi  in  16        cpu_addr[31:16]
//   idx      out IW        matching slave index, N_SLAVES when nothing matches
//   hit      out 1         some slave matched
//   match_oh out N_SLAVES  one-hot of the winning slave (all zero on miss)
//   Duplicate table entries resolve to the lowest index.
module femto_bus_decode
    import femto_bus_pkg::*;
#(
    parameter int                      N_SLAVES   = DEFAULT_N_SLAVES,
    parameter logic [16*N_SLAVES-1:0]  SLAVE_BASE = DEFAULT_SLAVE_BASE,
    parameter int                      IW         = $clog2(N_SLAVES + 1)
) (
    input  logic [15:0]         addr_hi,
    output logic [IW-1:0]       idx,
    output logic                hit,
    output logic [N_SLAVES-1:0] match_oh
);

    // Walk from the top index down so the lowest matching index is the
    // one left standing.
    always_comb begin
        idx      = IW'(N_SLAVES);
        hit      = 1'b0;
        match_oh = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (addr_hi == SLAVE_BASE[i*16 +: 16]) begin
                idx         = IW'(i);
                hit         = 1'b1;
                match_oh    = '0;
                match_oh[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/femto_bus_fabric.sv
// femto_bus_fabric
//   Memory-bus fabric between the FemtoRV32 core and N_SLAVES slaves.
//   clk, resetn          clock, asynchronous active-low reset
//   cpu                  CPU-side bus (femto_bus_if.slave)
//   s_addr/s_wdata/s_wmask  shared pass-through to all slaves
//   s_rd/s_wr            per-slave one-hot read/write strobes
//   s_rdata/s_rbusy/s_wbusy per-slave read data (packed) and busy
//   err_clear            pulse, clears the error log
//   err_code/err_addr/err_count  first error since clear + saturating count
//   quarantine           slaves disabled after a busy timeout (reset clears)
//   dbg_state            current FSM state
module femto_bus_fabric
    import femto_bus_pkg::*;
#(
    parameter int                      N_SLAVES       = DEFAULT_N_SLAVES,
    parameter logic [16*N_SLAVES-1:0]  SLAVE_BASE     = DEFAULT_SLAVE_BASE,
    parameter int                      TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     resetn,
    femto_bus_if.slave               cpu,
    output logic [31:0]              s_addr,
    output logic [31:0]              s_wdata,
    output logic [3:0]               s_wmask,
    output logic [N_SLAVES-1:0]      s_rd,
    output logic [N_SLAVES-1:0]      s_wr,
    input  logic [32*N_SLAVES-1:0]   s_rdata,
    input  logic [N_SLAVES-1:0]      s_rbusy,
    input  logic [N_SLAVES-1:0]      s_wbusy,
    input  logic                     err_clear,
    output logic [1:0]               err_code,
    output logic [31:0]              err_addr,
    output logic [7:0]               err_count,
    output logic [N_SLAVES-1:0]      quarantine,
    output state_e                   dbg_state
);

    localparam int             IW      = $clog2(N_SLAVES + 1);
    localparam logic [IW-1:0]  IDX_ERR = IW'(N_SLAVES);
    localparam int             TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  T_MAX   = TW'(TIMEOUT_CYCLES);

    logic [IW-1:0]       dec_idx;
    logic                dec_hit;
    logic [N_SLAVES-1:0] dec_oh;

    femto_bus_decode #(
        .N_SLAVES   (N_SLAVES),
        .SLAVE_BASE (SLAVE_BASE),
        .IW         (IW)
    ) u_decode (
        .addr_hi  (cpu.cpu_addr[31:16]),
        .idx      (dec_idx),
        .hit      (dec_hit),
        .match_oh (dec_oh)
    );

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [IW-1:0] sel_q;
    logic [31:0]   addr_q;
    logic          abort_q;

    // Read has priority: a write mask presented with rstrb is ignored.
    logic rd_req, wr_req, dec_ok;
    assign rd_req = cpu.cpu_rstrb;
    assign wr_req = (|cpu.cpu_wmask) & ~cpu.cpu_rstrb;
    assign dec_ok = dec_hit & ~(|(dec_oh & quarantine));

    assign s_addr  = cpu.cpu_addr;
    assign s_wdata = cpu.cpu_wdata;
    assign s_wmask = cpu.cpu_wmask;
    assign s_rd    = {N_SLAVES{rd_req}} & dec_oh & ~quarantine;
    assign s_wr    = {N_SLAVES{wr_req}} & dec_oh & ~quarantine;

    // Per-slave view of the registered selection.
    logic [31:0]         sel_rdata;
    logic                sel_rbusy, sel_wbusy, sel_quar;
    logic [N_SLAVES-1:0] sel_oh;

    always_comb begin
        sel_rdata = '0;
        sel_rbusy = 1'b0;
        sel_wbusy = 1'b0;
        sel_quar  = 1'b0;
        sel_oh    = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel_q == IW'(i)) begin
                sel_rdata = s_rdata[i*32 +: 32];
                sel_rbusy = s_rbusy[i];
                sel_wbusy = s_wbusy[i];
                sel_quar  = quarantine[i];
                sel_oh[i] = 1'b1;
            end
        end
    end

    logic        in_wait, sel_busy, ready, abort_now;
    logic        wr_ev, load_sel, err_event;
    logic [1:0]  err_code_new;
    logic [31:0] err_addr_new;

    always_comb begin
        in_wait   = (state_q != ST_IDLE);
        sel_busy  = (state_q == ST_RD_WAIT) ? sel_rbusy :
                    (state_q == ST_WR_WAIT) ? sel_wbusy : 1'b0;
        // A new request may be taken in IDLE or in the cycle a wait ends.
        ready     = ~in_wait | ~sel_busy;
        abort_now = in_wait & sel_busy & (timer_q == T_MAX);
        wr_ev     = wr_req & ready;
        load_sel  = rd_req | wr_ev;

        state_d = state_q;
        timer_d = timer_q;
        if (in_wait && sel_busy) begin
            if (abort_now) state_d = ST_IDLE;
            else           timer_d = timer_q + TW'(1);
        end else begin
            state_d = ST_IDLE;
            if (rd_req && dec_ok) begin
                state_d = ST_RD_WAIT;
                timer_d = '0;
            end else if (wr_req && dec_ok) begin
                state_d = ST_WR_WAIT;
                timer_d = '0;
            end
        end

        err_event    = abort_now | (load_sel & ~dec_ok);
        err_code_new = !abort_now ? ERR_UNMAPPED :
                       (state_q == ST_RD_WAIT) ? ERR_RD_TO : ERR_WR_TO;
        err_addr_new = abort_now ? addr_q : cpu.cpu_addr;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            sel_q      <= '0;
            addr_q     <= '0;
            abort_q    <= 1'b0;
            quarantine <= '0;
            err_code   <= ERR_NONE;
            err_addr   <= '0;
            err_count  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            if (load_sel) begin
                sel_q  <= dec_idx;
                addr_q <= cpu.cpu_addr;
            end
            if (abort_now) begin
                abort_q    <= 1'b1;
                quarantine <= quarantine | sel_oh;
            end else if (rd_req || wr_req) begin
                abort_q <= 1'b0;
            end
            // An error in the clear cycle wins and becomes the first entry.
            if (err_event) begin
                if (err_clear || err_code == ERR_NONE) begin
                    err_code <= err_code_new;
                    err_addr <= err_addr_new;
                end
                if (err_clear)                err_count <= 8'd1;
                else if (err_count != 8'hFF)  err_count <= err_count + 8'd1;
            end else if (err_clear) begin
                err_code  <= ERR_NONE;
                err_addr  <= '0;
                err_count <= '0;
            end
        end
    end

    assign cpu.cpu_rdata = (sel_q == IDX_ERR || sel_quar || abort_q || abort_now)
                         ? ERR_DATA : sel_rdata;
    assign cpu.cpu_rbusy = (state_q == ST_RD_WAIT) & sel_rbusy & ~abort_now;
    assign cpu.cpu_wbusy = (state_q == ST_WR_WAIT) & sel_wbusy & ~abort_now;
    assign dbg_state     = state_q;

endmodule
